mem_seq: RTL and testbench

- Sequencer/arbiter for the LC-3 memory block (MAR/MDR registers plus the synchronous dual-port RAM kernel, primary port A).
- Shares port A between two requesters: CPU control FSM and debug monitor.
- Drives ldMAR, ldMDR, selMDR and memWE for each read or write transaction.
- Tells the external BUS gating logic which requester drives BUS and whether BUS carries the address or the write data.
- Returns a one-cycle done pulse; the MDR holds the read data when done pulses.

---
 rtl/mem_seq_pkg.sv | 26 ++
 rtl/mem_seq_if.sv | 34 +++
 rtl/mem_seq_arb.sv | 40 ++++
 rtl/mem_seq.sv | 123 ++++++++++++
 tb/tb_mem_seq.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: state and owner encodings shared by the LC-3 memory sequencer files.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAR   = 3'd1,
        WAIT  = 3'd2,
        RDMDR = 3'd3,
        WRMDR = 3'd4,
        WRITE = 3'd5,
        DONE  = 3'd6
    } seqState_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    localparam int WAIT_CNT_W = 3;

    // Terminal-count timer preload: WAIT lasts readWait cycles ending at count 0.
    function automatic logic [WAIT_CNT_W-1:0] waitLoad(input int readWait);
        return WAIT_CNT_W'(readWait - 1);
    endfunction

endpackage

// File: rtl/mem_seq_if.sv
// mem_seq_if: requester handshakes plus the RAM strobes and BUS gating controls of the memory sequencer.
interface mem_seq_if;

    logic reqCpu;
    logic weCpu;
    logic reqDbg;
    logic weDbg;
    logic gntCpu;
    logic gntDbg;
    logic gateAddr;
    logic gateData;
    logic ldMAR;
    logic ldMDR;
    logic selMDR;
    logic memWE;
    logic doneCpu;
    logic doneDbg;
    logic busy;

    modport master (
        output reqCpu, weCpu, reqDbg, weDbg,
        input  gntCpu, gntDbg, gateAddr, gateData,
        input  ldMAR, ldMDR, selMDR, memWE,
        input  doneCpu, doneDbg, busy
    );

    modport slave (
        input  reqCpu, weCpu, reqDbg, weDbg,
        output gntCpu, gntDbg, gateAddr, gateData,
        output ldMAR, ldMDR, selMDR, memWE,
        output doneCpu, doneDbg, busy
    );

endinterface

// File: rtl/mem_seq_arb.sv
// mem_seq_arb: two-requester arbiter, round-robin (ARB_RR != 0) or fixed CPU priority.
module mem_seq_arb
    import mem_seq_pkg::*;
#(
    parameter int ARB_RR = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   reqCpu,
    input  logic   reqDbg,
    input  logic   update,
    output owner_t winner,
    output logic   anyReq
);

    owner_t lastOwner;

    // On a tie the requester not served last wins; reset leaves CPU as last so debug wins first.
    always_comb begin
        winner = OWN_CPU;
        if (reqCpu && reqDbg) begin
            if ((ARB_RR != 0) && (lastOwner == OWN_CPU)) begin
                winner = OWN_DBG;
            end
        end else if (reqDbg) begin
            winner = OWN_DBG;
        end
    end

    assign anyReq = reqCpu | reqDbg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastOwner <= OWN_CPU;
        end else if (update) begin
            lastOwner <= winner;
        end
    end

endmodule

// File: rtl/mem_seq.sv
// mem_seq: MAR/MDR/RAM port-A sequencer shared by the CPU control FSM and the debug monitor.
// Optional access counters cntRd/cntWr are built when MEM_SEQ_ACCESS_CNT_EN is defined.
//
// state | meaning
// IDLE  | no transaction; arbitrate and latch owner + we
// MAR   | owner address on BUS, load MAR
// WAIT  | RAM read latency, down-counter to terminal count 0
// RDMDR | load MDR from memOut
// WRMDR | owner write data on BUS, load MDR from BUS
// WRITE | single-cycle port-A write of MDR at MAR
// DONE  | one-cycle done pulse to owner
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int READ_WAIT = 1,
    parameter int ARB_RR    = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MEM_SEQ_ACCESS_CNT_EN
    output logic [CNT_W-1:0] cntRd,
    output logic [CNT_W-1:0] cntWr,
`endif
    mem_seq_if.slave         bus
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = waitLoad(READ_WAIT);

    seqState_t state, stateNxt;
    owner_t    owner, ownerNxt, winner;
    logic      isWrite, isWriteNxt;
    logic      anyReq, arbUpdate;
    logic [WAIT_CNT_W-1:0] waitCnt, waitCntNxt;

    mem_seq_arb #(.ARB_RR(ARB_RR)) uArb (
        .clk    (clk),
        .rst    (rst),
        .reqCpu (bus.reqCpu),
        .reqDbg (bus.reqDbg),
        .update (arbUpdate),
        .winner (winner),
        .anyReq (anyReq)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            owner   <= OWN_CPU;
            isWrite <= 1'b0;
            waitCnt <= '0;
        end else begin
            state   <= stateNxt;
            owner   <= ownerNxt;
            isWrite <= isWriteNxt;
            waitCnt <= waitCntNxt;
        end
    end

    always_comb begin
        stateNxt   = state;
        ownerNxt   = owner;
        isWriteNxt = isWrite;
        waitCntNxt = waitCnt;
        arbUpdate  = 1'b0;
        case (state)
            IDLE: begin
                if (anyReq) begin
                    stateNxt   = MAR;
                    ownerNxt   = winner;
                    isWriteNxt = (winner == OWN_DBG) ? bus.weDbg : bus.weCpu;
                    arbUpdate  = 1'b1;
                end
            end
            MAR: begin
                if (isWrite) begin
                    stateNxt = WRMDR;
                end else begin
                    stateNxt   = WAIT;
                    waitCntNxt = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (waitCnt == '0) begin
                    stateNxt = RDMDR;
                end else begin
                    waitCntNxt = waitCnt - WAIT_CNT_W'(1);
                end
            end
            RDMDR:   stateNxt = DONE;
            WRMDR:   stateNxt = WRITE;
            WRITE:   stateNxt = DONE;
            DONE:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    assign bus.busy     = (state != IDLE);
    assign bus.gntCpu   = (state != IDLE) && (owner == OWN_CPU);
    assign bus.gntDbg   = (state != IDLE) && (owner == OWN_DBG);
    assign bus.gateAddr = (state == MAR);
    assign bus.gateData = (state == WRMDR);
    assign bus.ldMAR    = (state == MAR);
    assign bus.ldMDR    = (state == RDMDR) || (state == WRMDR);
    assign bus.selMDR   = (state == RDMDR);
    assign bus.memWE    = (state == WRITE);
    assign bus.doneCpu  = (state == DONE) && (owner == OWN_CPU);
    assign bus.doneDbg  = (state == DONE) && (owner == OWN_DBG);

`ifdef MEM_SEQ_ACCESS_CNT_EN
    // RDMDR and WRITE always lead straight into DONE, so they mark DONE entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cntRd <= '0;
            cntWr <= '0;
        end else begin
            if (state == RDMDR) cntRd <= cntRd + CNT_W'(1);
            if (state == WRITE) cntWr <= cntWr + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_seq.sv
// Bench for mem_seq: dutA (defaults) drives a behavioural MAR/MDR/RAM model, dutB uses READ_WAIT=3 and fixed priority.
// With MEM_SEQ_ACCESS_CNT_EN defined the access counters are also checked (dutB counters are 2 bits wide).
`timescale 1ns/1ps
module tb_mem_seq;

    typedef struct {
        logic        owner;
        logic        we;
        logic [15:0] data;
        int          doneCyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reqCpuV [2];
    logic        weCpuV  [2];
    logic        reqDbgV [2];
    logic        weDbgV  [2];
    logic [10:0] outsV   [2];
    logic [15:0] addrCpu, dataCpu, addrDbg, dataDbg;

    mem_seq_if ifA ();
    mem_seq_if ifB ();

    assign ifA.reqCpu = reqCpuV[0];
    assign ifA.weCpu  = weCpuV[0];
    assign ifA.reqDbg = reqDbgV[0];
    assign ifA.weDbg  = weDbgV[0];
    assign ifB.reqCpu = reqCpuV[1];
    assign ifB.weCpu  = weCpuV[1];
    assign ifB.reqDbg = reqDbgV[1];
    assign ifB.weDbg  = weDbgV[1];

    // {gntCpu, gntDbg, gateAddr, gateData, ldMAR, ldMDR, selMDR, memWE, doneCpu, doneDbg, busy}
    assign outsV[0] = {ifA.gntCpu, ifA.gntDbg, ifA.gateAddr, ifA.gateData, ifA.ldMAR, ifA.ldMDR,
                       ifA.selMDR, ifA.memWE, ifA.doneCpu, ifA.doneDbg, ifA.busy};
    assign outsV[1] = {ifB.gntCpu, ifB.gntDbg, ifB.gateAddr, ifB.gateData, ifB.ldMAR, ifB.ldMDR,
                       ifB.selMDR, ifB.memWE, ifB.doneCpu, ifB.doneDbg, ifB.busy};

`ifdef MEM_SEQ_ACCESS_CNT_EN
    logic [15:0] cntRdA, cntWrA;
    logic [1:0]  cntRdB, cntWrB;
`endif

    mem_seq #(.READ_WAIT(1), .ARB_RR(1), .CNT_W(16)) dutA (
        .clk   (clk),
        .rst   (rst),
`ifdef MEM_SEQ_ACCESS_CNT_EN
        .cntRd (cntRdA),
        .cntWr (cntWrA),
`endif
        .bus   (ifA)
    );

    mem_seq #(.READ_WAIT(3), .ARB_RR(0), .CNT_W(2)) dutB (
        .clk   (clk),
        .rst   (rst),
`ifdef MEM_SEQ_ACCESS_CNT_EN
        .cntRd (cntRdB),
        .cntWr (cntWrB),
`endif
        .bus   (ifB)
    );

    // Behavioural MAR/MDR/RAM for dutA; RAM word index is the low address nibble.
    logic [15:0] mar, mdr, busVal;
    logic [15:0] ram [16];

    always_comb begin
        busVal = 16'h0000;
        if (ifA.gateAddr)      busVal = ifA.gntDbg ? addrDbg : addrCpu;
        else if (ifA.gateData) busVal = ifA.gntDbg ? dataDbg : dataCpu;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mar <= 16'h0000;
            mdr <= 16'h0000;
            for (int i = 0; i < 16; i++) ram[i] <= 16'h0000;
            ram[0] <= 16'h1234;
        end else begin
            if (ifA.ldMAR) mar <= busVal;
            if (ifA.ldMDR) mdr <= ifA.selMDR ? ram[mar[3:0]] : busVal;
            if (ifA.memWE) ram[mar[3:0]] <= mdr;
        end
    end

    int   nVec = 0;
    int   nErr = 0;
    exp_t sbA[$];
    exp_t sbB[$];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int readWaitOf(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [10:0] cpuStrobes(input logic we, input int k);
        case (k)
            1:       return 11'b10101000001;
            2:       return we ? 11'b10010100001 : 11'b10000000001;
            3:       return we ? 11'b10000001001 : 11'b10000110001;
            4:       return 11'b10000000101;
            default: return 11'b00000000000;
        endcase
    endfunction

    task automatic push(input int d, input logic own, input logic we, input logic [15:0] data,
                        input int doneCyc);
        exp_t e;
        e.owner   = own;
        e.we      = we;
        e.data    = data;
        e.doneCyc = doneCyc;
        if (d == 0) sbA.push_back(e);
        else        sbB.push_back(e);
    endtask

    // Pops an expectation whenever a done pulse is visible and checks owner, cycle and read data.
    task automatic sbPoll();
        exp_t e;
        logic haveExp;
        for (int d = 0; d < 2; d++) begin
            if (outsV[d][2] | outsV[d][1]) begin
                haveExp = 1'b0;
                if (d == 0 && sbA.size() != 0) begin haveExp = 1'b1; e = sbA.pop_front(); end
                if (d == 1 && sbB.size() != 0) begin haveExp = 1'b1; e = sbB.pop_front(); end
                if (!haveExp) begin
                    checkEq($sformatf("sb%0d_unexpected_done", d), 32'(outsV[d][2:1]), 32'd0);
                end else begin
                    checkEq($sformatf("sb%0d_done_owner", d), 32'(outsV[d][2:1]), e.owner ? 32'd1 : 32'd2);
                    checkEq($sformatf("sb%0d_done_cycle", d), cyc, e.doneCyc);
                    if (d == 0 && !e.we) checkEq("sb0_read_data", 32'(mdr), 32'(e.data));
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sbPoll();
    endtask

    task automatic setReq(input int d, input logic own, input logic val, input logic we);
        if (own) begin reqDbgV[d] = val; weDbgV[d] = we; end
        else     begin reqCpuV[d] = val; weCpuV[d] = we; end
    endtask

    task automatic runSingle(input int d, input logic own, input logic we, input logic [15:0] addr,
                             input logic [15:0] data, input logic [15:0] expData,
                             input logic strobes, input logic flipWe);
        int   t0;
        int   lat;
        logic seen;
        lat = we ? 4 : 3 + readWaitOf(d);
        t0  = cyc;
        if (own) begin addrDbg = addr; dataDbg = data; end
        else     begin addrCpu = addr; dataCpu = data; end
        setReq(d, own, 1'b1, we);
        push(d, own, we, expData, t0 + lat);
        seen = 1'b0;
        for (int k = 1; k <= 12 && !seen; k++) begin
            tick();
            if (strobes) checkEq($sformatf("strobe_%s_c%0d", we ? "wr" : "rd", k), 32'(outsV[d]),
                                 32'(cpuStrobes(we, k)));
            if (flipWe && k == 1) setReq(d, own, 1'b1, ~we);
            if (outsV[d][own ? 1 : 2]) begin
                seen = 1'b1;
                setReq(d, own, 1'b0, 1'b0);
            end
        end
        if (!seen) checkEq("txn_timeout", 32'd0, 32'd1);
        tick();
        if (strobes) checkEq("strobe_idle", 32'(outsV[d]), 32'd0);
    endtask

    // Two reads of word 0; dbgDelay=0 raises both together, otherwise debug joins at that cycle.
    task automatic tieRound(input int d, input logic first, input int dbgDelay);
        int   t0;
        int   lat;
        logic doneC, doneD;
        lat = 3 + readWaitOf(d);
        t0  = cyc;
        addrCpu = 16'h3000;
        addrDbg = 16'h3000;
        setReq(d, 1'b0, 1'b1, 1'b0);
        if (dbgDelay == 0) setReq(d, 1'b1, 1'b1, 1'b0);
        push(d, first, 1'b0, 16'h1234, t0 + lat);
        push(d, ~first, 1'b0, 16'h1234, t0 + 2 * lat + 1);
        doneC = 1'b0;
        doneD = 1'b0;
        for (int k = 1; k <= 40 && !(doneC && doneD); k++) begin
            tick();
            if (dbgDelay != 0 && k == dbgDelay) setReq(d, 1'b1, 1'b1, 1'b0);
            if (outsV[d][2]) begin doneC = 1'b1; setReq(d, 1'b0, 1'b0, 1'b0); end
            if (outsV[d][1]) begin doneD = 1'b1; setReq(d, 1'b1, 1'b0, 1'b0); end
        end
        if (!(doneC && doneD)) checkEq("tie_timeout", {30'd0, doneC, doneD}, 32'd3);
        tick();
    endtask

    initial begin
        int   nDone;
        int   t0;
        logic found;
        for (int d = 0; d < 2; d++) begin
            reqCpuV[d] = 1'b0; weCpuV[d] = 1'b0;
            reqDbgV[d] = 1'b0; weDbgV[d] = 1'b0;
        end
        addrCpu = 16'h0; dataCpu = 16'h0; addrDbg = 16'h0; dataDbg = 16'h0;

        rst = 1'b0;
        repeat (3) tick();
        checkEq("rst_outs_A", 32'(outsV[0]), 32'd0);
        checkEq("rst_outs_B", 32'(outsV[1]), 32'd0);
        rst = 1'b1;
        tick();

        // Reset while memWE is high must abort at once with no done pulse.
        addrCpu = 16'h3001;
        dataCpu = 16'hBEEF;
        setReq(0, 1'b0, 1'b1, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            tick();
            found = outsV[0][3];
        end
        checkEq("rst_reach_write", 32'(found), 32'd1);
        rst = 1'b0;
        setReq(0, 1'b0, 1'b0, 1'b0);
        #1;
        checkEq("rst_midwr_outs", 32'(outsV[0]), 32'd0);
        tick();
        checkEq("rst_hold_outs", 32'(outsV[0]), 32'd0);
        rst = 1'b1;
        tick();
        checkEq("rst_release_idle", 32'(outsV[0]), 32'd0);

        // Round-robin ties from reset: DBG, CPU three times.
        repeat (3) tieRound(0, 1'b1, 0);

        runSingle(0, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b1, 1'b0);
        runSingle(0, 1'b0, 1'b1, 16'h3001, 16'hBEEF, 16'h0000, 1'b1, 1'b1);
        runSingle(0, 1'b0, 1'b0, 16'h3001, 16'h0000, 16'hBEEF, 1'b1, 1'b0);
        runSingle(0, 1'b1, 1'b1, 16'h3002, 16'h5A5A, 16'h0000, 1'b0, 1'b0);
        runSingle(0, 1'b1, 1'b0, 16'h3002, 16'h0000, 16'h5A5A, 1'b0, 1'b0);
        tieRound(0, 1'b0, 2);

        // Fixed priority: CPU first every round.
        repeat (3) tieRound(1, 1'b0, 0);

        // Debug drops its request in WAIT; READ_WAIT=3 puts done at cycle 6.
        t0 = cyc;
        setReq(1, 1'b1, 1'b1, 1'b0);
        push(1, 1'b1, 1'b0, 16'h0000, t0 + 6);
        nDone = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 2) begin
                checkEq("b_wait_outs", 32'(outsV[1]), 32'h201);
                setReq(1, 1'b1, 1'b0, 1'b0);
            end
            if (outsV[1][1]) nDone++;
        end
        checkEq("b_drop_done_pulses", nDone, 1);

        runSingle(1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
        runSingle(1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);

`ifdef MEM_SEQ_ACCESS_CNT_EN
        rst = 1'b0;
        repeat (2) tick();
        checkEq("cnt_rst_A", {cntRdA, cntWrA}, 32'd0);
        rst = 1'b1;
        tick();
        runSingle(0, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b0, 1'b0);
        runSingle(0, 1'b1, 1'b1, 16'h3003, 16'h1111, 16'h0000, 1'b0, 1'b0);
        runSingle(0, 1'b0, 1'b1, 16'h3004, 16'h2222, 16'h0000, 1'b0, 1'b0);
        runSingle(0, 1'b1, 1'b0, 16'h3004, 16'h0000, 16'h2222, 1'b0, 1'b0);
        runSingle(0, 1'b0, 1'b1, 16'h3005, 16'h3333, 16'h0000, 1'b0, 1'b0);
        checkEq("cnt_rd_A", 32'(cntRdA), 32'd2);
        checkEq("cnt_wr_A", 32'(cntWrA), 32'd3);
        repeat (3) runSingle(1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        checkEq("cnt_wr_B_max", 32'(cntWrB), 32'd3);
        runSingle(1, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        checkEq("cnt_wr_B_wrap", 32'(cntWrB), 32'd0);
        checkEq("cnt_rd_B", 32'(cntRdB), 32'd0);
`endif

        checkEq("sb_left_A", sbA.size(), 0);
        checkEq("sb_left_B", sbB.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
